// File: rtl/shift_unit_pipe_if.sv
// Valid/ready operand and result bus for shift_unit_pipe.
// Master drives operands and out_ready; slave is the shift unit.
interface shift_unit_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned ShW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [ShW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_illegal
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR log shifter with valid/ready flow control.
// Stage 0 captures the operand; stages 1..STAGES each apply a slice of the mux levels.
module shift_unit_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input logic              clk,
  input logic              rst_n,
  shift_unit_pipe_if.slave bus
);
  localparam int Levels   = $clog2(WIDTH);
  localparam int PerStage = (Levels + int'(STAGES) - 1) / int'(STAGES);
  localparam int LastIdx  = int'(STAGES);

  localparam logic [2:0] OpSll = 3'd0;
  localparam logic [2:0] OpSrl = 3'd1;
  localparam logic [2:0] OpSra = 3'd2;
  localparam logic [2:0] OpRol = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  logic             vld_q   [STAGES+1];
  logic             vld_d   [STAGES+1];
  logic [WIDTH-1:0] data_q  [STAGES+1];
  logic [WIDTH-1:0] data_d  [STAGES+1];
  logic [Levels-1:0] shamt_q [STAGES+1];
  logic [Levels-1:0] shamt_d [STAGES+1];
  logic [2:0]       op_q    [STAGES+1];
  logic [2:0]       op_d    [STAGES+1];
  logic             sign_q  [STAGES+1];
  logic             sign_d  [STAGES+1];
  logic [TAG_W-1:0] tag_q   [STAGES+1];
  logic [TAG_W-1:0] tag_d   [STAGES+1];
  logic             zero_q;
  logic             zero_d;
  logic             adv;

  // One mux level: shift by a power of two, amt is at most WIDTH/2.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input logic             sign,
                                                   input int               amt);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    res  = d;
    case (op)
      OpSll:   res = d << amt;
      OpSrl:   res = d >> amt;
      OpSra:   res = (d >> amt) | fill;
      OpRol:   res = (d << amt) | (d >> (int'(WIDTH) - amt));
      OpRor:   res = (d >> amt) | (d << (int'(WIDTH) - amt));
      default: res = d;
    endcase
    return res;
  endfunction

  assign adv          = !vld_q[LastIdx] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    logic [WIDTH-1:0] acc;
    vld_d[0]   = bus.in_valid;
    data_d[0]  = bus.in_a;
    shamt_d[0] = bus.in_shamt;
    op_d[0]    = bus.in_op;
    sign_d[0]  = bus.in_a[WIDTH-1];
    tag_d[0]   = bus.in_tag;
    for (int s = 1; s <= LastIdx; s++) begin
      vld_d[s]   = vld_q[s-1];
      shamt_d[s] = shamt_q[s-1];
      op_d[s]    = op_q[s-1];
      sign_d[s]  = sign_q[s-1];
      tag_d[s]   = tag_q[s-1];
      acc        = data_q[s-1];
      for (int k = 0; k < Levels; k++) begin
        if ((k / PerStage) == (s - 1) && shamt_q[s-1][k]) begin
          acc = shift_level(acc, op_q[s-1], sign_q[s-1], 1 << k);
        end
      end
      data_d[s] = acc;
    end
  end

  assign zero_d = (data_d[LastIdx] == '0);

  // A stall freezes every slot, including bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= LastIdx; s++) begin
        vld_q[s]   <= 1'b0;
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        sign_q[s]  <= 1'b0;
        tag_q[s]   <= '0;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s <= LastIdx; s++) begin
        vld_q[s]   <= vld_d[s];
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        op_q[s]    <= op_d[s];
        sign_q[s]  <= sign_d[s];
        tag_q[s]   <= tag_d[s];
      end
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid   = vld_q[LastIdx];
  assign bus.out_data    = data_q[LastIdx];
  assign bus.out_tag     = tag_q[LastIdx];
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = (op_q[LastIdx] > OpRor);
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed 32/2 instance plus a random width/stage sweep.
module tb_shift_unit_pipe;
  localparam int TagW = 5;
  localparam int NSweep = 6;
  localparam int NBeats = 300;

  typedef struct {
    logic [63:0]     a;
    int unsigned     sh;
    logic [2:0]      op;
    logic [TagW-1:0] tag;
    bit              lat;
  } stim_t;

  typedef struct {
    logic [63:0]     data;
    logic [TagW-1:0] tag;
    bit              ill;
    int              acc;
    bit              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sw_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word shift/rotate on a w-bit value using plain arithmetic.
  function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input int unsigned sh,
                                            input logic [2:0] op, input int w);
    logic [63:0]        mask;
    logic [63:0]        a;
    logic signed [63:0] sa;
    logic [63:0]        r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    case (op)
      3'd0:    r = a << sh;
      3'd1:    r = a >> sh;
      3'd2: begin
        sa = signed'(a | (a[w-1] ? ~mask : 64'd0));
        r  = 64'(sa >>> sh);
      end
      3'd3:    r = (a << sh) | (a >> (w - int'(sh)));
      3'd4:    r = (a >> sh) | (a << (w - int'(sh)));
      default: r = a;
    endcase
    return r & mask;
  endfunction

  function automatic exp_t make_exp(input stim_t s, input int w, input int acc);
    exp_t e;
    e.data = ref_shift(s.a, s.sh, s.op, w);
    e.tag  = s.tag;
    e.ill  = (s.op > 3'd4);
    e.acc  = acc;
    e.lat  = s.lat;
    return e;
  endfunction

  // ---------------- Main instance: WIDTH=32, STAGES=2 ----------------
  shift_unit_pipe_if #(.WIDTH(32), .TAG_W(TagW)) m_if ();
  shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(TagW)) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m_if.slave)
  );

  stim_t pending[$];
  exp_t  m_q[$];
  bit    m_seen = 1'b0;
  int    m_npop = 0;

  task automatic push(input logic [2:0] op, input logic [63:0] a, input int unsigned sh,
                      input logic [TagW-1:0] tag, input bit lat);
    stim_t s;
    s.a = a; s.sh = sh; s.op = op; s.tag = tag; s.lat = lat;
    pending.push_back(s);
  endtask

  // Feeder: presents the head of pending; acceptance is judged just before the edge.
  initial begin
    exp_t e;
    m_if.in_valid = 1'b0;
    m_if.in_a     = '0;
    m_if.in_shamt = '0;
    m_if.in_op    = '0;
    m_if.in_tag   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pending.size() > 0) begin
        m_if.in_valid = 1'b1;
        m_if.in_a     = pending[0].a[31:0];
        m_if.in_shamt = 5'(pending[0].sh);
        m_if.in_op    = pending[0].op;
        m_if.in_tag   = pending[0].tag;
      end else begin
        m_if.in_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_n && m_if.in_valid && m_if.in_ready && pending.size() > 0) begin
        e = make_exp(pending[0], 32, cyc + 1);
        m_q.push_back(e);
        void'(pending.pop_front());
      end
    end
  end

  // Monitor: every presented result must match the scoreboard head, stalled or not.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      chk("m_in_ready_rule", 64'(m_if.in_ready), 64'(!m_if.out_valid || m_if.out_ready));
      if (m_if.out_valid) begin
        chk("m_expected_pending", 64'(m_q.size() > 0), 64'd1);
        if (m_q.size() > 0) begin
          e = m_q[0];
          chk("m_data", 64'(m_if.out_data), e.data);
          chk("m_tag", 64'(m_if.out_tag), 64'(e.tag));
          chk("m_zero", 64'(m_if.out_zero), 64'(e.data == 64'd0));
          chk("m_illegal", 64'(m_if.out_illegal), 64'(e.ill));
          if (e.lat && !m_seen) chk("m_latency", 64'(cyc - e.acc), 64'd2);
          m_seen = 1'b1;
          if (m_if.out_ready) begin
            void'(m_q.pop_front());
            m_seen = 1'b0;
            m_npop++;
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && (pending.size() > 0 || m_q.size() > 0); i++) @(negedge clk);
    chk(name, 64'(pending.size() + m_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- Random sweep instances ----------------
  for (genvar gi = 0; gi < NSweep; gi++) begin : g_sw
    localparam int W  = (gi < 2) ? 8 : (gi < 4) ? 32 : 64;
    localparam int S  = (gi % 2 == 0) ? 1 : $clog2(W);
    localparam int SW = $clog2(W);

    shift_unit_pipe_if #(.WIDTH(W), .TAG_W(TagW)) ifc ();
    shift_unit_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TagW)) u_dut (
      .clk  (clk),
      .rst_n(rst_sw_n),
      .bus  (ifc.slave)
    );

    exp_t q[$];
    bit   done = 1'b0;

    initial begin
      stim_t       s;
      logic [63:0] r;
      int          sent;
      ifc.in_valid  = 1'b0;
      ifc.in_a      = '0;
      ifc.in_shamt  = '0;
      ifc.in_op     = '0;
      ifc.in_tag    = '0;
      ifc.out_ready = 1'b0;
      sent = 0;
      wait (rst_sw_n === 1'b1);
      for (int c = 0; c < 4000 && sent < NBeats; c++) begin
        @(posedge clk);
        #1;
        r    = {$urandom(), $urandom()};
        s.a  = r;
        s.sh = $urandom_range(W - 1);
        s.op = ($urandom_range(15) < 13) ? 3'($urandom_range(4)) : 3'($urandom_range(7, 5));
        s.tag = TagW'($urandom());
        s.lat = 1'b0;
        ifc.in_valid  = ($urandom_range(3) != 0);
        ifc.in_a      = r[W-1:0];
        ifc.in_shamt  = SW'(s.sh);
        ifc.in_op     = s.op;
        ifc.in_tag    = s.tag;
        ifc.out_ready = ($urandom_range(2) != 0);
        @(negedge clk);
        if (ifc.in_valid && ifc.in_ready) begin
          q.push_back(make_exp(s, W, 0));
          sent++;
        end
      end
      chk($sformatf("sw%0d_sent", gi), 64'(sent), 64'(NBeats));
      @(posedge clk);
      #1;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      chk($sformatf("sw%0d_drain", gi), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_sw_n && ifc.out_valid) begin
        chk($sformatf("sw%0d_expected_pending", gi), 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q[0];
          chk($sformatf("sw%0d_data", gi), 64'(ifc.out_data), e.data);
          chk($sformatf("sw%0d_tag", gi), 64'(ifc.out_tag), 64'(e.tag));
          chk($sformatf("sw%0d_zero", gi), 64'(ifc.out_zero), 64'(e.data == 64'd0));
          chk($sformatf("sw%0d_illegal", gi), 64'(ifc.out_illegal), 64'(e.ill));
          if (ifc.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- Main directed sequence ----------------
  initial begin
    int npop0;
    int pushed;
    bit all_done;
    rst_n          = 1'b0;
    rst_sw_n       = 1'b0;
    m_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
    chk("rst_out_data", 64'(m_if.out_data), 64'd0);
    chk("rst_out_tag", 64'(m_if.out_tag), 64'd0);
    chk("rst_out_zero", 64'(m_if.out_zero), 64'd0);
    chk("rst_out_illegal", 64'(m_if.out_illegal), 64'd0);
    chk("rst_in_ready", 64'(m_if.in_ready), 64'd1);

    // Lone beat into an empty pipe for the latency check.
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b1;
    push(3'd0, 64'h0000_0001, 31, 5'd1, 1'b1);
    wait_idle("idle_latency");

    push(3'd0, 64'h8000_0000, 1, 5'd2, 1'b0);
    push(3'd2, 64'h8000_00F0, 4, 5'd3, 1'b0);
    push(3'd1, 64'h8000_00F0, 4, 5'd4, 1'b0);
    push(3'd2, 64'h7FFF_FFFF, 31, 5'd5, 1'b0);
    push(3'd4, 64'h0000_00FF, 8, 5'd6, 1'b0);
    push(3'd3, 64'h8000_0001, 1, 5'd7, 1'b0);
    for (int op = 0; op < 5; op++) push(3'(op), 64'hA5A5_0F0F, 0, 5'(8 + op), 1'b0);
    push(3'd7, 64'h1234_5678, 13, 5'd13, 1'b0);
    push(3'd0, 64'h1234_5678, 4, 5'd14, 1'b0);
    wait_idle("idle_directed");

    // Backpressure: six back-to-back tags, three-cycle stall on first output.
    for (int t = 1; t <= 6; t++) push(3'd0, 64'({$urandom()}), $urandom_range(31), 5'(t), 1'b0);
    for (int i = 0; i < 20 && !m_if.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_first_valid", 64'(m_if.out_valid), 64'd1);
    m_if.out_ready = 1'b0;
    npop0 = m_npop;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_in_ready", 64'(m_if.in_ready), 64'd0);
      chk("bp_stall_out_valid", 64'(m_if.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    m_if.out_ready = 1'b1;
    wait_idle("idle_bp");
    chk("bp_count", 64'(m_npop - npop0), 64'd6);

    // Reset with two beats in flight.
    m_if.out_ready = 1'b0;
    push(3'd3, 64'hDEAD_BEEF, 5, 5'd20, 1'b0);
    push(3'd1, 64'hCAFE_F00D, 9, 5'd21, 1'b0);
    for (int i = 0; i < 20 && !m_if.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rip_out_valid_before", 64'(m_if.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rip_out_valid_async", 64'(m_if.out_valid), 64'd0);
    chk("rip_out_data_async", 64'(m_if.out_data), 64'd0);
    m_q.delete();
    pending.delete();
    m_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    m_if.out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rip_no_output", 64'(m_if.out_valid), 64'd0);
    end

    // Short random run on the main instance.
    pushed = 0;
    for (int c = 0; c < 2000 && pushed < 150; c++) begin
      @(posedge clk);
      #1;
      m_if.out_ready = ($urandom_range(3) != 0);
      if (pending.size() < 2) begin
        push(3'($urandom_range(7)), 64'({$urandom()}), $urandom_range(31), 5'($urandom()), 1'b0);
        pushed++;
      end
    end
    m_if.out_ready = 1'b1;
    wait_idle("idle_random");

    all_done = 1'b0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                 g_sw[3].done && g_sw[4].done && g_sw[5].done;
    end
    chk("sweeps_done", 64'(all_done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
